// File: rtl/mcu51_int_ctrl.sv
// rtl/mcu51_int_ctrl.sv - MCU51 interrupt arbiter/scheduler with two-level nesting and RETI release
module mcu51_int_ctrl #(
    parameter int          N_SRC      = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int          VEC_STRIDE = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [7:0]       ie,
    input  logic [7:0]       ip,
    input  logic [N_SRC-1:0] src_req,
    input  logic             hold_off,
    output logic             irq,
    output logic [15:0]      irq_vec,
    input  logic             irq_ack,
    output logic [N_SRC-1:0] ack_src,
    input  logic             reti,
    output logic [1:0]       in_svc
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               irq_q, irq_d;
    logic [15:0]        vec_q, vec_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               lvl_q, lvl_d;
    logic [1:0]         svc_q, svc_d;

    logic [N_SRC-1:0]   elig, hi_cand, lo_cand, pick;
    logic               win_valid, win_hi;
    logic [IDX_W-1:0]   win_idx;
    logic [15:0]        win_vec;
    logic               unused_bits;

    assign unused_bits = ^{ie, ip};

    // A high-level source may preempt low service; nothing preempts high service.
    always_comb begin
        elig      = {N_SRC{ie[7]}} & ie[N_SRC-1:0] & src_req;
        hi_cand   = elig & ip[N_SRC-1:0] & {N_SRC{~svc_q[1]}};
        lo_cand   = elig & ~ip[N_SRC-1:0] & {N_SRC{svc_q == 2'b00}};
        win_hi    = |hi_cand;
        win_valid = win_hi | (|lo_cand);
        pick      = win_hi ? hi_cand : lo_cand;
        win_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pick[i]) win_idx = IDX_W'(i);
        end
        win_vec   = VEC_BASE + 16'(VEC_STRIDE) * 16'(win_idx);
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        lvl_d   = lvl_q;
        svc_d   = svc_q;

        // RETI release is applied before any same-cycle in-service set.
        if (reti) begin
            if (svc_d[1]) svc_d[1] = 1'b0;
            else          svc_d[0] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_valid && !hold_off) begin
                    state_d = ST_PEND;
                    irq_d   = 1'b1;
                    vec_d   = win_vec;
                    idx_d   = win_idx;
                    lvl_d   = win_hi;
                end
            end
            ST_PEND: begin
                if (irq_ack) begin
                    state_d = ST_ACK;
                    irq_d   = 1'b0;
                    if (lvl_q) svc_d[1] = 1'b1;
                    else       svc_d[0] = 1'b1;
                end else if (win_valid) begin
                    vec_d = win_vec;
                    idx_d = win_idx;
                    lvl_d = win_hi;
                end else begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        ack_src = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_src[i] = (state_q == ST_ACK) && (idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            vec_q   <= 16'h0000;
            idx_q   <= '0;
            lvl_q   <= 1'b0;
            svc_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
            svc_q   <= svc_d;
        end
    end

    assign irq     = irq_q;
    assign irq_vec = vec_q;
    assign in_svc  = svc_q;

endmodule

// File: tb/tb_mcu51_int_ctrl.sv
// tb/tb_mcu51_int_ctrl.sv - table-driven bench for mcu51_int_ctrl
module tb_mcu51_int_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  ie, ip;
    logic [4:0]  src_req;
    logic        hold_off, irq_ack, reti;
    logic        irq;
    logic [15:0] irq_vec;
    logic [4:0]  ack_src;
    logic [1:0]  in_svc;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  ie;
        logic [7:0]  ip;
        logic [4:0]  req;
        logic        hold;
        logic        ack;
        logic        reti;
        logic        e_irq;
        logic [15:0] e_vec;
        logic [4:0]  e_ack;
        logic [1:0]  e_svc;
    } vec_t;

    vec_t tbl[$];

    mcu51_int_ctrl dut (
        .CLK      (CLK),
        .reset    (reset),
        .ie       (ie),
        .ip       (ip),
        .src_req  (src_req),
        .hold_off (hold_off),
        .irq      (irq),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack),
        .ack_src  (ack_src),
        .reti     (reti),
        .in_svc   (in_svc)
    );

    always #5 CLK = ~CLK;

    function automatic void add(input logic [7:0] a_ie, input logic [7:0] a_ip,
                                input logic [4:0] a_req, input logic a_hold,
                                input logic a_ack, input logic a_reti,
                                input logic e_irq, input logic [15:0] e_vec,
                                input logic [4:0] e_ack, input logic [1:0] e_svc);
        vec_t v;
        v.ie = a_ie; v.ip = a_ip; v.req = a_req; v.hold = a_hold;
        v.ack = a_ack; v.reti = a_reti; v.e_irq = e_irq; v.e_vec = e_vec;
        v.e_ack = e_ack; v.e_svc = e_svc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a_ie, input logic [7:0] a_ip, input logic [4:0] a_req,
                         input logic a_hold, input logic a_ack, input logic a_reti);
        ie = a_ie; ip = a_ip; src_req = a_req; hold_off = a_hold; irq_ack = a_ack; reti = a_reti;
    endtask

    initial begin
        reset = 1'b1;
        drive(8'h00, 8'h00, 5'b0, 1'b0, 1'b0, 1'b0);

        // Basic vectoring, release on RETI
        add(8'h82, 8'h00, 5'b00010, 0, 0, 0, 1, 16'h000B, 5'b00000, 2'b00);
        add(8'h82, 8'h00, 5'b00010, 0, 1, 0, 0, 16'h0000, 5'b00010, 2'b01);
        add(8'h82, 8'h00, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h82, 8'h00, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        // High-priority serial beats IE0; IE0 blocked until RETI
        add(8'h9F, 8'h10, 5'b10001, 0, 0, 0, 1, 16'h0023, 5'b00000, 2'b00);
        add(8'h9F, 8'h10, 5'b10001, 0, 1, 0, 0, 16'h0000, 5'b10000, 2'b10);
        add(8'h9F, 8'h10, 5'b00001, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b10);
        add(8'h9F, 8'h10, 5'b00001, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b10);
        add(8'h9F, 8'h10, 5'b00001, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        add(8'h9F, 8'h10, 5'b00001, 0, 0, 0, 1, 16'h0003, 5'b00000, 2'b00);
        add(8'h9F, 8'h10, 5'b00001, 0, 1, 0, 0, 16'h0000, 5'b00001, 2'b01);
        add(8'h9F, 8'h10, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h9F, 8'h10, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        // Nesting: low TF1 then high IE1; extra RETI is a no-op
        add(8'h8C, 8'h04, 5'b01000, 0, 0, 0, 1, 16'h001B, 5'b00000, 2'b00);
        add(8'h8C, 8'h04, 5'b01000, 0, 1, 0, 0, 16'h0000, 5'b01000, 2'b01);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h8C, 8'h04, 5'b00100, 0, 0, 0, 1, 16'h0013, 5'b00000, 2'b01);
        add(8'h8C, 8'h04, 5'b00100, 0, 1, 0, 0, 16'h0000, 5'b00100, 2'b11);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b11);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        // Withdraw, then ack in the same cycle the flag drops
        add(8'h82, 8'h00, 5'b00010, 0, 0, 0, 1, 16'h000B, 5'b00000, 2'b00);
        add(8'h82, 8'h00, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b00);
        add(8'h82, 8'h00, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b00);
        add(8'h82, 8'h00, 5'b00010, 0, 0, 0, 1, 16'h000B, 5'b00000, 2'b00);
        add(8'h82, 8'h00, 5'b00000, 0, 1, 0, 0, 16'h0000, 5'b00010, 2'b01);
        add(8'h82, 8'h00, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h82, 8'h00, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        // hold_off blocks entry but not an existing request
        add(8'h81, 8'h00, 5'b00001, 1, 0, 0, 0, 16'h0000, 5'b00000, 2'b00);
        add(8'h81, 8'h00, 5'b00001, 1, 0, 0, 0, 16'h0000, 5'b00000, 2'b00);
        add(8'h81, 8'h00, 5'b00001, 0, 0, 0, 1, 16'h0003, 5'b00000, 2'b00);
        add(8'h81, 8'h00, 5'b00001, 1, 0, 0, 1, 16'h0003, 5'b00000, 2'b00);
        add(8'h81, 8'h00, 5'b00001, 0, 1, 0, 0, 16'h0000, 5'b00001, 2'b01);
        add(8'h81, 8'h00, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h81, 8'h00, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        // Late higher-priority takeover while pending
        add(8'h8F, 8'h00, 5'b01000, 0, 0, 0, 1, 16'h001B, 5'b00000, 2'b00);
        add(8'h8F, 8'h00, 5'b01001, 0, 0, 0, 1, 16'h0003, 5'b00000, 2'b00);
        add(8'h8F, 8'h00, 5'b01001, 0, 1, 0, 0, 16'h0000, 5'b00001, 2'b01);
        add(8'h8F, 8'h00, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h8F, 8'h00, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        // EA cleared while pending; stray ack in IDLE ignored
        add(8'h82, 8'h00, 5'b00010, 0, 0, 0, 1, 16'h000B, 5'b00000, 2'b00);
        add(8'h02, 8'h00, 5'b00010, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b00);
        add(8'h00, 8'h00, 5'b00000, 0, 1, 0, 0, 16'h0000, 5'b00000, 2'b00);
        // RETI in the same cycle as the ACK set: clear low, then set high
        add(8'h8C, 8'h04, 5'b01000, 0, 0, 0, 1, 16'h001B, 5'b00000, 2'b00);
        add(8'h8C, 8'h04, 5'b01000, 0, 1, 0, 0, 16'h0000, 5'b01000, 2'b01);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h8C, 8'h04, 5'b00100, 0, 0, 0, 1, 16'h0013, 5'b00000, 2'b01);
        add(8'h8C, 8'h04, 5'b00100, 0, 1, 1, 0, 16'h0000, 5'b00100, 2'b10);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b10);
        add(8'h8C, 8'h04, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);
        // Lowest index wins within a level; low blocked while low in service
        add(8'h83, 8'h00, 5'b00011, 0, 0, 0, 1, 16'h0003, 5'b00000, 2'b00);
        add(8'h83, 8'h00, 5'b00011, 0, 1, 0, 0, 16'h0000, 5'b00001, 2'b01);
        add(8'h83, 8'h00, 5'b00010, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h83, 8'h00, 5'b00010, 0, 0, 0, 0, 16'h0000, 5'b00000, 2'b01);
        add(8'h83, 8'h00, 5'b00000, 0, 0, 1, 0, 16'h0000, 5'b00000, 2'b00);

        @(posedge CLK); #1;
        chk("rst irq", 16'(irq), 16'h0);
        chk("rst irq_vec", irq_vec, 16'h0000);
        chk("rst ack_src", 16'(ack_src), 16'h0);
        chk("rst in_svc", 16'(in_svc), 16'h0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ie, tbl[i].ip, tbl[i].req, tbl[i].hold, tbl[i].ack, tbl[i].reti);
            @(posedge CLK); #1;
            chk($sformatf("v%0d irq", i), 16'(irq), 16'(tbl[i].e_irq));
            if (tbl[i].e_irq) chk($sformatf("v%0d irq_vec", i), irq_vec, tbl[i].e_vec);
            chk($sformatf("v%0d ack_src", i), 16'(ack_src), 16'(tbl[i].e_ack));
            chk($sformatf("v%0d in_svc", i), 16'(in_svc), 16'(tbl[i].e_svc));
        end

        // Async reset while in ACK: outputs clear without waiting for a clock edge
        drive(8'h82, 8'h00, 5'b00010, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        chk("ackrst pend irq", 16'(irq), 16'h1);
        irq_ack = 1'b1;
        @(posedge CLK); #1;
        chk("ackrst in ack ack_src", 16'(ack_src), 16'h02);
        #2 reset = 1'b1;
        #1;
        chk("ackrst async ack_src", 16'(ack_src), 16'h0);
        chk("ackrst async in_svc", 16'(in_svc), 16'h0);
        chk("ackrst async irq_vec", irq_vec, 16'h0000);
        drive(8'h82, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        chk("ackrst held ack_src", 16'(ack_src), 16'h0);
        reset = 1'b0;

        // Async reset mid-PEND, then recovery with the request still present
        src_req = 5'b00010;
        @(posedge CLK); #1;
        chk("pendrst pend irq", 16'(irq), 16'h1);
        #1 reset = 1'b1;
        #1;
        chk("pendrst async irq", 16'(irq), 16'h0);
        #1 reset = 1'b0;
        @(posedge CLK); #1;
        chk("pendrst recover irq", 16'(irq), 16'h1);
        chk("pendrst recover vec", irq_vec, 16'h000B);
        src_req = 5'b00000;
        @(posedge CLK); #1;
        chk("pendrst withdraw irq", 16'(irq), 16'h0);
        chk("pendrst withdraw ack_src", 16'(ack_src), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
